// File: rtl/led_frame_stream_loader.sv
// Streamed frame loader: hunts for a sync byte, loads 64 payload bytes plus an XOR
// checksum into the back bank of a ping-pong buffer, and swaps banks on request.
module led_frame_stream_loader #(
    parameter int          FRAME_BYTES    = 64,
    parameter int          ADDR_W         = 6,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              swap_req,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              frame_valid,
    output logic              pending,
    output logic              err_checksum,
    output logic              err_timeout,
    output logic [15:0]       frames_loaded
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LOAD = 2'd1,
        CSUM = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [23:0]       TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;

    state_t            state;
    state_t            next_state;
    logic              front_sel;
    logic [ADDR_W-1:0] byte_cnt;
    logic [7:0]        csum;
    logic [23:0]       timeout_cnt;

    logic [7:0] bank0 [FRAME_BYTES];
    logic [7:0] bank1 [FRAME_BYTES];

    logic accept;
    logic sync_hit;
    logic load_wr;
    logic csum_take;
    logic csum_ok;
    logic csum_bad;
    logic timeout_hit;
    logic swap_fire;

    // While a verified frame waits, hunting stalls so it can never be overwritten.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (state)
                HUNT:    in_ready = ~pending;
                LOAD:    in_ready = 1'b1;
                CSUM:    in_ready = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept    = in_valid && in_ready && !flush;
    assign swap_fire = swap_req && pending && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        sync_hit    = 1'b0;
        load_wr     = 1'b0;
        csum_take   = 1'b0;
        csum_ok     = 1'b0;
        csum_bad    = 1'b0;
        timeout_hit = 1'b0;
        if (flush) begin
            next_state = HUNT;
        end else begin
            case (state)
                HUNT: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        sync_hit   = 1'b1;
                        next_state = LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        load_wr = 1'b1;
                        if (byte_cnt == LAST_ADDR) begin
                            next_state = CSUM;
                        end
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        timeout_hit = 1'b1;
                        next_state  = HUNT;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        csum_take  = 1'b1;
                        next_state = HUNT;
                        if (in_data == csum) begin
                            csum_ok = 1'b1;
                        end else begin
                            csum_bad = 1'b1;
                        end
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        timeout_hit = 1'b1;
                        next_state  = HUNT;
                    end
                end
                default: next_state = HUNT;
            endcase
        end
    end

    // Load-path bookkeeping; flush clears it but never touches the displayed side.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt     <= '0;
            csum         <= 8'h00;
            timeout_cnt  <= 24'd0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_checksum <= csum_bad;
            err_timeout  <= timeout_hit;
            if (flush || sync_hit) begin
                byte_cnt    <= '0;
                csum        <= 8'h00;
                timeout_cnt <= 24'd0;
            end else if (load_wr) begin
                byte_cnt    <= byte_cnt + 1'b1;
                csum        <= csum ^ in_data;
                timeout_cnt <= 24'd0;
            end else if (csum_take || timeout_hit) begin
                timeout_cnt <= 24'd0;
            end else if (state != HUNT) begin
                timeout_cnt <= timeout_cnt + 24'd1;
            end
        end
    end

    // A checksum pass and a swap can never coincide: pending is 0 throughout a load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending       <= 1'b0;
            front_sel     <= 1'b0;
            frame_valid   <= 1'b0;
            frames_loaded <= 16'd0;
        end else begin
            if (flush) begin
                pending <= 1'b0;
            end else if (csum_ok) begin
                pending <= 1'b1;
            end else if (swap_fire) begin
                pending <= 1'b0;
            end
            if (swap_fire) begin
                front_sel     <= ~front_sel;
                frame_valid   <= 1'b1;
                frames_loaded <= frames_loaded + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_wr) begin
            if (front_sel) begin
                bank0[byte_cnt] <= in_data;
            end else begin
                bank1[byte_cnt] <= in_data;
            end
        end
    end

    // Uses the pre-swap select, so a read issued in the swap cycle sees the old bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else if (!frame_valid) begin
            rd_data <= 8'h00;
        end else if (front_sel) begin
            rd_data <= bank1[rd_addr];
        end else begin
            rd_data <= bank0[rd_addr];
        end
    end

endmodule

// File: tb/tb_led_frame_stream_loader.sv
// Self-checking bench for led_frame_stream_loader: frame loading, checksum and
// timeout errors, backpressure, and swap/flush interactions.
module tb_led_frame_stream_loader;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       swap_req;
    logic       flush;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_valid;
    logic       pending;
    logic       err_checksum;
    logic       err_timeout;
    logic [15:0] frames_loaded;

    int vec_count  = 0;
    int miss_count = 0;

    logic [7:0] exp_q [$];
    rd_vec_t    ramp_tab [6];
    rd_vec_t    ff_tab   [6];
    rd_vec_t    a5_tab   [6];

    led_frame_stream_loader #(
        .FRAME_BYTES   (64),
        .ADDR_W        (6),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(24'd20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .swap_req     (swap_req),
        .flush        (flush),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_valid  (frame_valid),
        .pending      (pending),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .frames_loaded(frames_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Presents one byte and waits (bounded) until the loader takes it.
    task automatic apply_stimulus(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check_output("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_payload(input bit ramp, input logic [7:0] fill);
        apply_stimulus(8'hA5);
        for (int i = 0; i < 64; i++) begin
            apply_stimulus(ramp ? 8'(i) : fill);
        end
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    // Scoreboard read: expectation queued with the address, popped when data returns.
    task automatic read_table(input rd_vec_t tab [6], input string name);
        for (int i = 0; i < 6; i++) begin
            rd_addr = tab[i].addr;
            exp_q.push_back(tab[i].exp);
            tick();
            check_output(name, {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        end
    endtask

    initial begin
        logic [5:0] addrs [6];
        int n;
        int ready_high;

        addrs[0] = 6'd0;  addrs[1] = 6'd5;  addrs[2] = 6'd31;
        addrs[3] = 6'd32; addrs[4] = 6'd62; addrs[5] = 6'd63;
        for (int i = 0; i < 6; i++) begin
            ramp_tab[i] = '{addrs[i], {2'b00, addrs[i]}};
            ff_tab[i]   = '{addrs[i], 8'hFF};
            a5_tab[i]   = '{addrs[i], 8'hA5};
        end

        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        swap_req = 1'b0;
        flush    = 1'b0;
        rd_addr  = 6'd0;
        tick();
        tick();
        check_output("ready_in_reset", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        check_output("rst_pending", {31'd0, pending}, 32'd0);
        check_output("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check_output("rst_frames_loaded", {16'd0, frames_loaded}, 32'd0);

        // Garbage, then a ramp frame with a good checksum.
        apply_stimulus(8'h13);
        apply_stimulus(8'h77);
        send_payload(1'b1, 8'h00);
        apply_stimulus(8'h00);
        check_output("good_pending", {31'd0, pending}, 32'd1);
        check_output("good_no_err", {31'd0, err_checksum}, 32'd0);
        check_output("pending_blocks_ready", {31'd0, in_ready}, 32'd0);
        check_output("rd_zero_invalid", {24'd0, rd_data}, 32'd0);
        pulse_swap();
        check_output("swap1_frame_valid", {31'd0, frame_valid}, 32'd1);
        check_output("swap1_pending", {31'd0, pending}, 32'd0);
        check_output("swap1_loaded", {16'd0, frames_loaded}, 32'd1);
        read_table(ramp_tab, "ramp_read");

        // Bad checksum: single-cycle error pulse, front bank untouched.
        send_payload(1'b1, 8'h00);
        apply_stimulus(8'h01);
        check_output("csum_err_pulse", {31'd0, err_checksum}, 32'd1);
        check_output("csum_err_pending", {31'd0, pending}, 32'd0);
        tick();
        check_output("csum_err_width", {31'd0, err_checksum}, 32'd0);
        check_output("csum_err_ready", {31'd0, in_ready}, 32'd1);
        read_table(ramp_tab, "front_after_bad");

        // Backpressure while a verified frame waits.
        send_payload(1'b0, 8'hFF);
        apply_stimulus(8'h00);
        in_valid   = 1'b1;
        in_data    = 8'hA5;
        ready_high = 0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) ready_high++;
            tick();
        end
        check_output("bp_ready_cycles", ready_high, 32'd0);
        check_output("bp_pending", {31'd0, pending}, 32'd1);
        pulse_swap();
        check_output("bp_ready_after_swap", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        check_output("bp_loaded", {16'd0, frames_loaded}, 32'd2);
        read_table(ff_tab, "ff_read");

        // Inter-byte timeout in the middle of a payload.
        apply_stimulus(8'hA5);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(8'(8'h40 + i));
        end
        n = 0;
        while (!err_timeout && n < 40) begin
            tick();
            n++;
        end
        check_output("timeout_cycles", n, 32'd20);
        tick();
        check_output("timeout_width", {31'd0, err_timeout}, 32'd0);
        check_output("timeout_pending", {31'd0, pending}, 32'd0);
        apply_stimulus(8'h00);
        send_payload(1'b0, 8'hA5);
        apply_stimulus(8'h00);
        check_output("post_timeout_pending", {31'd0, pending}, 32'd1);
        pulse_swap();
        check_output("post_timeout_loaded", {16'd0, frames_loaded}, 32'd3);
        read_table(a5_tab, "a5_read");

        // Checksum accepted in the same cycle as swap_req: no swap yet.
        send_payload(1'b1, 8'h00);
        in_valid = 1'b1;
        in_data  = 8'h00;
        swap_req = 1'b1;
        tick();
        in_valid = 1'b0;
        swap_req = 1'b0;
        check_output("sim_pending", {31'd0, pending}, 32'd1);
        check_output("sim_loaded", {16'd0, frames_loaded}, 32'd3);
        read_table(a5_tab, "sim_front_kept");
        pulse_swap();
        check_output("sim_swap_loaded", {16'd0, frames_loaded}, 32'd4);
        check_output("sim_swap_pending", {31'd0, pending}, 32'd0);
        read_table(ramp_tab, "sim_ramp_read");

        // flush beats swap_req when both arrive with a pending frame.
        send_payload(1'b0, 8'hFF);
        apply_stimulus(8'h00);
        check_output("flush_pre_pending", {31'd0, pending}, 32'd1);
        swap_req = 1'b1;
        flush    = 1'b1;
        tick();
        swap_req = 1'b0;
        flush    = 1'b0;
        check_output("flush_pending", {31'd0, pending}, 32'd0);
        check_output("flush_loaded", {16'd0, frames_loaded}, 32'd4);
        check_output("flush_frame_valid", {31'd0, frame_valid}, 32'd1);
        check_output("flush_ready", {31'd0, in_ready}, 32'd1);
        read_table(ramp_tab, "flush_front_kept");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/led_frame_stream_loader.md
Name: led_frame_stream_loader

Overview:
- Upstream stage of the multi-frame cube controller. It replaces static preloaded animation ROMs with frames streamed in at runtime, for example from a UART RX byte stream.
- It accepts a framed byte stream (sync byte, 64 payload bytes, XOR checksum) and writes each frame into the back bank of a ping-pong 2x64x8 buffer.
- The controller swaps banks at its frame boundary. It reads the front bank by address, in the same way the single-frame driver fetches data_to_latch.

Parameters:
- FRAME_BYTES, 64, payload bytes per frame (8 layers x 8 bytes); must be a power of two.
- ADDR_W, 6, log2(FRAME_BYTES).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 24'd500000, maximum idle cycles between accepted bytes inside a frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte this cycle
- swap_req  in  1  one-cycle pulse from controller at frame boundary (NEXT_FRAME)
- flush  in  1  synchronous abort/clear of load path
- rd_addr  in  ADDR_W  front-bank read address
- rd_data  out  8  front-bank byte, registered
- frame_valid  out  1  front bank holds a verified frame
- pending  out  1  verified frame waiting in back bank
- err_checksum  out  1  one-cycle pulse on checksum mismatch
- err_timeout  out  1  one-cycle pulse on inter-byte timeout
- frames_loaded  out  16  count of successful swaps, wraps at 16'hFFFF -> 0

Behaviour:
- Reset: rst_n is synchronous, active-low, on clock clk. On reset:
  - state=HUNT, front bank=0, pending=0, frame_valid=0, rd_data=0.
  - err_checksum=0, err_timeout=0, frames_loaded=0, byte counter=0, checksum accumulator=0, timeout counter=0.
  - Buffer contents are not cleared.
- Transfer: a byte is taken when in_valid && in_ready are both 1 on a rising edge.
- in_ready:
  - 1 in LOAD and CSUM.
  - In HUNT, in_ready = ~pending.
  - 0 while rst_n=0.
- State HUNT:
  - Accepted byte == SYNC_BYTE -> LOAD; clear byte counter, checksum and timeout counter.
  - Any other byte is discarded silently.
- State LOAD:
  - Each accepted byte is written to back bank[byte_cnt] and XORed into the checksum; byte_cnt increments.
  - Byte FRAME_BYTES-1 accepted -> CSUM.
  - A SYNC_BYTE value inside the payload is data, not a resync.
- State CSUM:
  - Accepted byte == checksum -> set pending, go to HUNT.
  - Otherwise pulse err_checksum, leave pending=0, go to HUNT.
  - The back bank is left dirty on a mismatch; the front bank is never touched.
- Timeout:
  - In LOAD and CSUM, the counter increments on each cycle with no accepted byte and clears on each accepted byte.
  - Reaching TIMEOUT_CYCLES pulses err_timeout and forces HUNT.
- Swap:
  - swap_req && pending: the front-bank select toggles, pending clears, frame_valid sets, frames_loaded increments. All take effect on the next edge.
  - swap_req with pending=0: no effect; frame_valid holds its value.
  - Simultaneous events: swap_req sampled in the same cycle that CSUM sets pending sees the old pending=0, so no swap happens; the frame swaps at the next swap_req.
- Backpressure: a new frame is never loaded over a pending one. HUNT holds in_ready=0 until the swap.
- Read path:
  - rd_data <= front_bank[rd_addr] each cycle; latency is 1 cycle.
  - rd_data outputs 0 when frame_valid=0.
  - The swap and the read bank change on the same edge: the read issued in the swap cycle returns old-bank data. This is glitch-free for the controller because it reads only during DRIVE_FRAME.
- flush:
  - Forces HUNT, clears pending, byte_cnt, checksum and timeout counter.
  - front bank, frame_valid and frames_loaded are unchanged.
  - flush has priority over stream input and over swap_req in the same cycle.
- Error pulses are one cycle wide and are never simultaneous.
- Memory: two 64x8 arrays, each with one write port (loader) and one synchronous read port (display), inferable as block RAM.

Test Plan:
- Reset with in_valid=0 -> in_ready=1, frame_valid=0, pending=0, rd_data=8'h00, frames_loaded=0.
- Stream 8'h13, 8'h77 (garbage), then 8'hA5, payload bytes 8'h00..8'h3F (value=index), checksum 8'h00 -> pending=1. Then:
  - pulse swap_req -> frame_valid=1, pending=0, frames_loaded=1.
  - rd_addr=6'd5 -> rd_data=8'h05 one cycle later.
- Same frame with checksum 8'h01 -> err_checksum high exactly 1 cycle, pending=0, front-bank rd_data for addr 5 still 8'h05.
- Backpressure:
  - Complete a valid frame with all payload bytes 8'hFF (checksum 8'h00), do not swap; present 8'hA5 -> in_ready=0 for 100 cycles.
  - Pulse swap_req -> in_ready=1 next cycle, rd_data at any addr = 8'hFF, frames_loaded=2.
- Timeout: with TIMEOUT_CYCLES=20, send 8'hA5 plus 10 bytes, then idle 20 cycles -> err_timeout pulse, state back to HUNT. Then a full valid frame loads and swaps normally.
- Simultaneous events:
  - Checksum byte accepted in the same cycle as swap_req -> no swap, pending=1; next swap_req -> swap.
  - flush asserted together with swap_req while pending=1 -> pending=0, no swap, frames_loaded unchanged.
